// File: rtl/pla_sched_pkg.sv
// Shared types and defaults for the PLA evaluation scheduler.
// Holds the FSM state encoding, default widths and the settle-range helpers.
// No logic of its own; imported by the arbiter and the top.
package pla_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  localparam int NREQ_DEF   = 4;
  localparam int IN_W_DEF   = 33;
  localparam int OUT_W_DEF  = 23;
  localparam int SETTLE_DEF = 2;
  localparam int CNT_W_DEF  = 16;

  // Settle counter is sized for the largest legal hold time.
  localparam int SETTLE_MIN   = 1;
  localparam int SETTLE_MAX   = 15;
  localparam int SETTLE_CNT_W = 4;

  function automatic bit settle_ok(input int s);
    return (s >= SETTLE_MIN) && (s <= SETTLE_MAX);
  endfunction

endpackage

// File: rtl/pla_eval_sched_arb.sv
// Round-robin arbiter: picks the first requester at or after the pointer, cyclically.
// Combinational grant (zero latency); pointer moves past the winner on advance.
// No backpressure of its own; the caller qualifies the grant with advance.
module rr_arbiter
  import pla_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic                     advance,
  output logic [NREQ-1:0]          gnt,
  output logic [$clog2(NREQ)-1:0]  idx,
  output logic                     any
);

  localparam int IDX_W = $clog2(NREQ);

  logic [IDX_W-1:0] ptr;
  int               pos;

  // Cyclic priority search starting at ptr; the first hit wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = (int'(ptr) + k) % NREQ;
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = IDX_W'(pos);
      end
    end
  end

  // After a grant the winner drops to lowest priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/pla_eval_sched.sv
// Time-shares one combinational PLA among NREQ requesters, round-robin.
// Accept -> rsp_valid after SETTLE_CYC+1 cycles; back-to-back jobs with no bubble.
// rsp_ready low holds the result and blocks all new accepts.
module pla_eval_sched
  import pla_sched_pkg::*;
#(
  parameter int NREQ       = NREQ_DEF,
  parameter int IN_W       = IN_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int SETTLE_CYC = SETTLE_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*IN_W-1:0]    req_data,
  output logic [IN_W-1:0]         pla_x,
  input  logic [OUT_W-1:0]        pla_z,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [OUT_W-1:0]        rsp_data,
  output logic                    busy,
  output logic [CNT_W-1:0]        done_cnt
);

  localparam int ID_W = $clog2(NREQ);
  localparam logic [SETTLE_CNT_W-1:0] CNT_LOAD = SETTLE_CNT_W'(SETTLE_CYC - 1);

  if (!settle_ok(SETTLE_CYC)) begin : g_settle_range
    $error("pla_eval_sched: SETTLE_CYC out of range 1..15");
  end

  state_t                  state;
  logic [SETTLE_CNT_W-1:0] cnt;
  logic [NREQ-1:0]         gnt;
  logic [ID_W-1:0]         win;
  logic                    any_req;
  logic                    open_slot;
  logic                    take;
  logic [IN_W-1:0]         win_data;

  // A new job may start from idle, or in the very cycle the previous result is consumed.
  assign open_slot = (state == S_IDLE) || ((state == S_RESP) && rsp_ready);
  assign take      = open_slot && any_req;
  assign req_ready = open_slot ? gnt : '0;
  assign win_data  = req_data[int'(win)*IN_W +: IN_W];

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid),
    .advance(take),
    .gnt    (gnt),
    .idx    (win),
    .any    (any_req)
  );

  // Scheduler FSM: launch vector, wait for the PLA to settle, hold result until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      pla_x     <= '0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
      done_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (take) begin
            pla_x  <= win_data;
            rsp_id <= win;
            cnt    <= CNT_LOAD;
            busy   <= 1'b1;
            state  <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (cnt == '0) begin
            rsp_data  <= pla_z;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            done_cnt  <= done_cnt + 1'b1;
            if (take) begin
              pla_x  <= win_data;
              rsp_id <= win;
              cnt    <= CNT_LOAD;
              state  <= S_DRIVE;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pla_eval_sched.sv
// Randomized bench: two schedulers (SETTLE_CYC=2/CNT_W=16 and SETTLE_CYC=1/CNT_W=4)
// are driven by independent requester models and compared every cycle against a
// job-timeline reference model (accept cycle, response window, cyclic priority).
module tb_pla_eval_sched;

  localparam int NREQ  = 4;
  localparam int IN_W  = 33;
  localparam int OUT_W = 23;
  localparam int MAXC  = 4096;

  localparam int M_RAND  = 0;
  localparam int M_ALL   = 1;
  localparam int M_STALL = 2;
  localparam int M_ONE   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]      req_valid [2];
  logic [NREQ*IN_W-1:0] req_data  [2];
  logic                 rsp_ready [2];
  logic [OUT_W-1:0]     pla_z     [2];
  logic [NREQ-1:0]      req_ready [2];
  logic [IN_W-1:0]      pla_x     [2];
  logic                 rsp_valid [2];
  logic [1:0]           rsp_id    [2];
  logic [OUT_W-1:0]     rsp_data  [2];
  logic                 busy      [2];
  logic [15:0]          done0;
  logic [3:0]           done1;

  pla_eval_sched #(.NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W), .SETTLE_CYC(2), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_data(req_data[0]),
    .pla_x(pla_x[0]), .pla_z(pla_z[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_id(rsp_id[0]),
    .rsp_data(rsp_data[0]), .busy(busy[0]), .done_cnt(done0)
  );

  pla_eval_sched #(.NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W), .SETTLE_CYC(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_data(req_data[1]),
    .pla_x(pla_x[1]), .pla_z(pla_z[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_id(rsp_id[1]),
    .rsp_data(rsp_data[1]), .busy(busy[1]), .done_cnt(done1)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model state, per scheduler instance.
  logic [OUT_W-1:0] zhist [2][MAXC];
  bit               out_act [2];
  int               out_a   [2];
  int               out_id  [2];
  logic [IN_W-1:0]  last_x  [2];
  int               ptr     [2];
  int               done    [2];
  bit               pend    [2][NREQ];
  logic [IN_W-1:0]  pdat    [2][NREQ];

  function automatic int settle_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic logic [63:0] done_exp(input int d);
    return (d == 0) ? 64'(done[d] & 16'hFFFF) : 64'(done[d] & 4'hF);
  endfunction

  function automatic logic [63:0] done_got(input int d);
    return (d == 0) ? 64'(done0) : 64'(done1);
  endfunction

  function automatic logic [IN_W-1:0] rnd_vec();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    return v[IN_W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      out_act[d] = 1'b0;
      out_a[d]   = 0;
      out_id[d]  = 0;
      last_x[d]  = '0;
      ptr[d]     = 0;
      done[d]    = 0;
      for (int i = 0; i < NREQ; i++) begin
        pend[d][i] = 1'b0;
        pdat[d][i] = '0;
      end
    end
  endtask

  task automatic check_reset_outputs(input string ph);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s d%0d pla_x", ph, d), 64'(pla_x[d]), 64'd0);
      chk($sformatf("%s d%0d rsp_valid", ph, d), 64'(rsp_valid[d]), 64'd0);
      chk($sformatf("%s d%0d rsp_id", ph, d), 64'(rsp_id[d]), 64'd0);
      chk($sformatf("%s d%0d rsp_data", ph, d), 64'(rsp_data[d]), 64'd0);
      chk($sformatf("%s d%0d busy", ph, d), 64'(busy[d]), 64'd0);
      chk($sformatf("%s d%0d done_cnt", ph, d), done_got(d), 64'd0);
      chk($sformatf("%s d%0d req_ready", ph, d), 64'(req_ready[d]), 64'd0);
    end
  endtask

  task automatic one_cycle(input int mode);
    bit          raise;
    bit          rv;
    bit          hs;
    bit          can;
    int          w;
    int          s;
    logic [3:0]  exp_rdy;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pend[d][i]) begin
          if (mode == M_RAND && $urandom_range(0, 19) == 0) pend[d][i] = 1'b0;
        end else begin
          raise = (mode == M_ALL) || (mode == M_ONE && i == 1) ||
                  ((mode == M_RAND || mode == M_STALL) && $urandom_range(0, 3) == 0);
          if (raise) begin
            pend[d][i] = 1'b1;
            pdat[d][i] = (mode == M_ONE) ? 33'h1_0000_0001 : rnd_vec();
          end
        end
        req_valid[d][i] = pend[d][i];
        req_data[d][i*IN_W +: IN_W] = pdat[d][i];
      end
      rsp_ready[d] = (mode == M_STALL) ? 1'b0 :
                     (mode == M_RAND)  ? ($urandom_range(0, 9) < 7) : 1'b1;
      pla_z[d] = OUT_W'($urandom());
      zhist[d][cyc] = pla_z[d];
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      s  = settle_of(d);
      rv = out_act[d] && (cyc >= out_a[d] + s + 1);
      hs = rv && rsp_ready[d];
      can = !out_act[d] || hs;
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (w < 0 && req_valid[d][(ptr[d] + k) % NREQ]) w = (ptr[d] + k) % NREQ;
      end
      exp_rdy = (can && w >= 0) ? (4'b0001 << w) : 4'b0000;
      chk($sformatf("c%0d d%0d req_ready", cyc, d), 64'(req_ready[d]), 64'(exp_rdy));
      chk($sformatf("c%0d d%0d rsp_valid", cyc, d), 64'(rsp_valid[d]), 64'(rv));
      chk($sformatf("c%0d d%0d busy", cyc, d), 64'(busy[d]), 64'(out_act[d] && cyc > out_a[d]));
      chk($sformatf("c%0d d%0d pla_x", cyc, d), 64'(pla_x[d]), 64'(last_x[d]));
      chk($sformatf("c%0d d%0d done_cnt", cyc, d), done_got(d), done_exp(d));
      if (rv) begin
        chk($sformatf("c%0d d%0d rsp_id", cyc, d), 64'(rsp_id[d]), 64'(out_id[d]));
        chk($sformatf("c%0d d%0d rsp_data", cyc, d), 64'(rsp_data[d]), 64'(zhist[d][out_a[d] + s]));
      end
      if (hs) begin
        done[d]++;
        out_act[d] = 1'b0;
      end
      if (exp_rdy != 4'b0000) begin
        out_act[d] = 1'b1;
        out_a[d]   = cyc;
        out_id[d]  = w;
        last_x[d]  = pdat[d][w];
        pend[d][w] = 1'b0;
        ptr[d]     = (w + 1) % NREQ;
      end
    end
    cyc++;
  endtask

  task automatic run(input int mode, input int n);
    for (int i = 0; i < n; i++) one_cycle(mode);
  endtask

  // Reset while the SETTLE_CYC=2 instance is in its first drive cycle (count still 1).
  task automatic reset_mid();
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      one_cycle(M_ALL);
      if (out_act[0] && cyc == out_a[0] + 1) hit = 1'b1;
    end
    chk("rst_wait_drive", 64'(hit), 64'd1);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = '0;
      rsp_ready[d] = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_rst");
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = '0;
      req_data[d]  = '0;
      rsp_ready[d] = 1'b0;
      pla_z[d]     = '0;
    end
    model_reset();
    rst_n = 1'b0;
    #1 check_reset_outputs("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run(M_ONE, 12);
    run(M_ALL, 24);
    run(M_STALL, 12);
    run(M_RAND, 250);
    reset_mid();
    run(M_ALL, 12);
    run(M_RAND, 300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
